approx_rc_adder_pipe: RTL and testbench

Pipelined, runtime-configurable approximate ripple-carry adder with an in-line error monitor, for power/MSE characterisation of approximate adders.

- Each transaction adds two WIDTH-bit operands. The lowest k bit positions use the approximate cell (S = X, Cout = Y, carry-in ignored); the remaining positions are exact full adders.
- The block computes the exact sum in parallel, emits the signed error per result, and accumulates SSE, sample count and maximum absolute error for bench-free MSE measurement.

---
 rtl/approx_adder_pkg.sv | 28 ++
 rtl/approx_adder_slice.sv | 48 ++++
 rtl/approx_rc_adder_pipe.sv | 160 ++++++++++++++++
 tb/tb_approx_rc_adder_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg
//   Shared definitions for the pipelined approximate ripple-carry adder:
//   adder cell kinds, a single-bit cell evaluator and a saturating adder
//   used by the error statistics.
package approx_adder_pkg;

   // CELL_APPROX_51_15: S = X, Cout = Y, carry-in ignored.
   typedef enum logic {CELL_EXACT, CELL_APPROX_51_15} cell_e;

   // Returns {cout, s} for one bit position.
   function automatic logic [1:0] fa_cell(input cell_e kind, input logic x,
                                          input logic y, input logic z);
      if (kind == CELL_APPROX_51_15) return {y, x};
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   // acc + inc clamped to 2^w - 1 (w <= 64).
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [63:0] lim;
      lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      sum = {1'b0, acc} + {1'b0, inc};
      return (sum > {1'b0, lim}) ? lim : sum[63:0];
   endfunction

endpackage

// File: rtl/approx_adder_slice.sv
// approx_adder_slice
//   Combinational SB-bit slice evaluating the approximate and the exact
//   ripple chains side by side. Bit positions below k use the approximate
//   cell; the rest are exact full adders.
// Ports:
//   a, b          operand bits of this slice
//   base          absolute bit index of a[0]
//   k             number of approximate LSB positions (already clamped)
//   ca_in, ce_in  approximate / exact carry-in
//   sa, se        approximate / exact slice sums
//   ca_out, ce_out approximate / exact carry-out
module approx_adder_slice
   import approx_adder_pkg::*;
#(
   parameter int SB = 4,
   parameter int IW = 5
)(
   input  logic [SB-1:0] a,
   input  logic [SB-1:0] b,
   input  logic [IW-1:0] base,
   input  logic [IW-1:0] k,
   input  logic          ca_in,
   input  logic          ce_in,
   output logic [SB-1:0] sa,
   output logic [SB-1:0] se,
   output logic          ca_out,
   output logic          ce_out
);

   logic  ca, ce;
   cell_e kind;

   always_comb begin
      ca   = ca_in;
      ce   = ce_in;
      sa   = '0;
      se   = '0;
      kind = CELL_EXACT;
      for (int j = 0; j < SB; j++) begin
         kind = (int'(base) + j < int'(k)) ? CELL_APPROX_51_15 : CELL_EXACT;
         {ca, sa[j]} = fa_cell(kind, a[j], b[j], ca);
         {ce, se[j]} = fa_cell(CELL_EXACT, a[j], b[j], ce);
      end
      ca_out = ca;
      ce_out = ce;
   end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// approx_rc_adder_pipe
//   Pipelined approximate ripple-carry adder with in-line error monitor.
//   Stage s resolves bits [s*STAGE_BITS +: STAGE_BITS] of both the
//   approximate and the exact sum; operand bits not yet consumed and the
//   clamped k travel alongside (skew registers). Global-stall pipeline.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        operand handshake; in_a, in_b, cfg_k sampled
//   out_valid/out_ready      result handshake; out_sum, out_err
//   clr_stats                synchronous statistics clear
//   sse, cnt, max_abs_err    saturating error statistics
module approx_rc_adder_pipe
   import approx_adder_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int STAGE_BITS = 4,
   parameter int ACC_W      = 48
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [$clog2(WIDTH+1)-1:0] cfg_k,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH:0]             out_sum,
   output logic [WIDTH+1:0]           out_err,
   input  logic                       clr_stats,
   output logic [ACC_W-1:0]           sse,
   output logic [31:0]                cnt,
   output logic [WIDTH:0]             max_abs_err
);

   localparam int NSTAGE = WIDTH / STAGE_BITS;
   localparam int SB     = STAGE_BITS;
   localparam int KW     = $clog2(WIDTH+1);

   logic                  advance;
   logic [KW-1:0]         k_eff;
   logic [NSTAGE-1:0]     vld_pipe;
   logic [WIDTH+1:0]      exact_ext, approx_ext, abs_err;
   logic [2*WIDTH+3:0]    sq;
   logic                  hs;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;
   assign k_eff    = (cfg_k > KW'(WIDTH)) ? KW'(WIDTH) : cfg_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          vld_pipe <= '0;
      else if (advance) vld_pipe <= NSTAGE'({vld_pipe, in_valid});
   end

   for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
      localparam int LO = s * SB;      // first bit resolved here
      localparam int HI = LO + SB;     // bits below HI are final after this stage

      logic [WIDTH-LO-1:0] op_a, op_b; // operand bits not yet consumed
      logic [KW-1:0]       k_in;
      logic                ca_in, ce_in;
      logic [SB-1:0]       sa_n, se_n;
      logic                ca_n, ce_n;
      logic [HI-1:0]       sa_d, se_d, sa_q, se_q;
      logic                ca_q, ce_q;

      if (s == 0) begin : g_src
         assign op_a  = in_a;
         assign op_b  = in_b;
         assign k_in  = k_eff;
         assign ca_in = 1'b0;
         assign ce_in = 1'b0;
         assign sa_d  = sa_n;
         assign se_d  = se_n;
      end else begin : g_src
         assign op_a  = g_stg[s-1].g_skew.a_q;
         assign op_b  = g_stg[s-1].g_skew.b_q;
         assign k_in  = g_stg[s-1].g_skew.k_q;
         assign ca_in = g_stg[s-1].ca_q;
         assign ce_in = g_stg[s-1].ce_q;
         assign sa_d  = {sa_n, g_stg[s-1].sa_q};
         assign se_d  = {se_n, g_stg[s-1].se_q};
      end

      approx_adder_slice #(.SB(SB), .IW(KW)) u_slice (
         .a      (op_a[SB-1:0]),
         .b      (op_b[SB-1:0]),
         .base   (KW'(LO)),
         .k      (k_in),
         .ca_in  (ca_in),
         .ce_in  (ce_in),
         .sa     (sa_n),
         .se     (se_n),
         .ca_out (ca_n),
         .ce_out (ce_n)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sa_q <= '0;
            se_q <= '0;
            ca_q <= 1'b0;
            ce_q <= 1'b0;
         end else if (advance) begin
            sa_q <= sa_d;
            se_q <= se_d;
            ca_q <= ca_n;
            ce_q <= ce_n;
         end
      end

      // The last stage has nothing left to forward.
      if (s < NSTAGE-1) begin : g_skew
         logic [WIDTH-HI-1:0] a_q, b_q;
         logic [KW-1:0]       k_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
               k_q <= '0;
            end else if (advance) begin
               a_q <= op_a[WIDTH-LO-1:SB];
               b_q <= op_b[WIDTH-LO-1:SB];
               k_q <= k_in;
            end
         end
      end
   end

   assign out_valid  = vld_pipe[NSTAGE-1];
   assign out_sum    = {g_stg[NSTAGE-1].ca_q, g_stg[NSTAGE-1].sa_q};
   assign approx_ext = {1'b0, out_sum};
   assign exact_ext  = {1'b0, g_stg[NSTAGE-1].ce_q, g_stg[NSTAGE-1].se_q};
   assign out_err    = exact_ext - approx_ext;

   // |err| always fits WIDTH+1 bits; the top bit is kept for the compare.
   assign abs_err = out_err[WIDTH+1] ? -out_err : out_err;
   assign sq      = abs_err * abs_err;
   assign hs      = out_valid & out_ready;

   // clr_stats with a handshake restarts the statistics from that sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sse         <= '0;
         cnt         <= '0;
         max_abs_err <= '0;
      end else if (hs) begin
         sse <= ACC_W'(sat_add(clr_stats ? 64'd0 : 64'(sse), 64'(sq), ACC_W));
         cnt <= 32'(sat_add(clr_stats ? 64'd0 : 64'(cnt), 64'd1, 32));
         if (clr_stats || abs_err > {1'b0, max_abs_err})
            max_abs_err <= abs_err[WIDTH:0];
      end else if (clr_stats) begin
         sse         <= '0;
         cnt         <= '0;
         max_abs_err <= '0;
      end
   end

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Scoreboard bench for approx_rc_adder_pipe (WIDTH=16, STAGE_BITS=4).
module tb_approx_rc_adder_pipe;

   localparam int W  = 16;
   localparam int SB = 4;
   localparam int AW = 48;
   localparam int KW = 5;
   localparam int NS = W / SB;

   logic          clk = 0, rst = 0;
   logic          in_valid = 0, in_ready, out_valid, out_ready = 1, clr_stats = 0;
   logic [W-1:0]  in_a = '0, in_b = '0;
   logic [KW-1:0] cfg_k = '0;
   logic [W:0]    out_sum, max_abs_err;
   logic [W+1:0]  out_err;
   logic [AW-1:0] sse;
   logic [31:0]   cnt;

   typedef struct {
      logic [W:0]   sum;
      logic [W+1:0] err;
      int           acc_cyc;
      bit           lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0;

   approx_rc_adder_pipe #(.WIDTH(W), .STAGE_BITS(SB), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .cfg_k(cfg_k), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
      .clr_stats(clr_stats), .sse(sse), .cnt(cnt), .max_abs_err(max_abs_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Holds operands until accepted; queues the hand-computed result.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [KW-1:0] k, input logic [W:0] s, input int err);
      exp_t e;
      bit   acc = 0;
      in_valid = 1; in_a = a; in_b = b; cfg_k = k;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc       = 1;
            e.sum     = s;
            e.err     = (W+2)'(err);
            e.acc_cyc = cyc + 1;
            e.lat     = out_ready;
            exp_q.push_back(e);
            n_acc++;
         end
         @(posedge clk); #1;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk); @(negedge clk);
   endtask

   // Monitor: every output handshake pops one expected result.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 64'(out_valid), 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("out_sum", 64'(out_sum), 64'(e.sum));
               chk("out_err", 64'(out_err), 64'(e.err));
               if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(NS - 1));
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int seen;
      #2 rst = 1;
      repeat (2) @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_sse", 64'(sse), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_max", 64'(max_abs_err), 64'd0);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;

      // exact carry through all stages, then approximate LSBs
      send(16'hFFFF, 16'h0001, 0, 17'h10000, 0);
      send(16'h007F, 16'h0001, 7, 17'h0007F, 1);
      send(16'h0000, 16'h0040, 7, 17'h00080, -64);
      in_valid = 0;
      drain();
      chk("stat_sse", 64'(sse), 64'd4097);
      chk("stat_cnt", 64'(cnt), 64'd3);
      chk("stat_max", 64'(max_abs_err), 64'd64);

      // clear alone
      @(posedge clk); #1; clr_stats = 1;
      @(posedge clk); #1; clr_stats = 0;
      chk("clr_sse", 64'(sse), 64'd0);
      chk("clr_cnt", 64'(cnt), 64'd0);
      chk("clr_max", 64'(max_abs_err), 64'd0);

      // fully approximate, k clamped
      send(16'h8000, 16'h8000, 16, 17'h18000, -32768);
      send(16'h8000, 16'h8000, 20, 17'h18000, -32768);
      send(16'hFFFF, 16'hFFFF, 20, 17'h1FFFF, -1);
      send(16'h00FF, 16'h0001, 31, 17'h000FF, 1);
      in_valid = 0;
      drain();
      chk("stat_max_k16", 64'(max_abs_err), 64'd32768);

      // clr_stats coinciding with a handshake (err = +1)
      @(posedge clk); #1;
      out_ready = 0;
      send(16'h007F, 16'h0001, 7, 17'h0007F, 1);
      in_valid = 0;
      repeat (4) @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      clr_stats = 1; out_ready = 1;
      @(posedge clk); #1; clr_stats = 0;
      chk("clrhs_sse", 64'(sse), 64'd1);
      chk("clrhs_cnt", 64'(cnt), 64'd1);
      chk("clrhs_max", 64'(max_abs_err), 64'd1);

      // backpressure with k toggling per push
      out_ready = 0;
      n_acc = 0;
      fork
         begin
            send(16'h1234, 16'h1111, 0, 17'h02345, 0);
            send(16'h007F, 16'h0001, 7, 17'h0007F, 1);
            send(16'hFFFF, 16'h0001, 0, 17'h10000, 0);
            send(16'h0000, 16'h0040, 7, 17'h00080, -64);
            send(16'h007F, 16'h0001, 0, 17'h00080, 0);
            send(16'h00FF, 16'h0001, 7, 17'h000FF, 1);
            in_valid = 0;
         end
         begin
            repeat (8) @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_accepts", 64'(n_acc), 64'd4);
            for (int i = 0; i < 3; i++) begin
               chk("bp_valid_hold", 64'(out_valid), 64'd1);
               chk("bp_sum_hold", 64'(out_sum), 64'h02345);
               chk("bp_err_hold", 64'(out_err), 64'd0);
               @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1;
         end
      join
      drain();
      chk("bp_cnt", 64'(cnt), 64'd7);

      // async reset with three transactions in flight
      @(posedge clk); #1;
      send(16'h0001, 16'h0001, 0, 17'h00002, 0);
      send(16'h0003, 16'h0005, 0, 17'h00008, 0);
      send(16'h00F0, 16'h000F, 0, 17'h000FF, 0);
      in_valid = 0;
      #1 rst = 1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_sse", 64'(sse), 64'd0);
      chk("arst_cnt", 64'(cnt), 64'd0);
      chk("arst_max", 64'(max_abs_err), 64'd0);
      exp_q.delete();
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("arst_no_stale", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
